fifo_checker: RTL and testbench
===============================

FIFO_CHECKER -- requirements
Module: fifo_checker

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the observed FIFO data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the observed FIFO depth (power of two, >= 4).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-004 clk  in  1  single clock; all sampling on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset of the checker.
REQ-006 dut_rst_n  in  1  observed DUT reset, active-low, sampled synchronously.
REQ-007 chk_en  in  1  enables comparison; model tracking continues when low.
REQ-008 wr_en, rd_en  in  1 each  observed DUT requests.
REQ-009 data_in, data_out  in  DATA_WIDTH each  observed DUT write and read data.
REQ-010 wr_ack, overflow, underflow, full, empty, almostfull, almostempty  in  1 each  observed DUT status.
REQ-011 err_vec  out  8  per-cycle mismatch flags, fifo_chk_err_e bit order.
REQ-012 err_sticky  out  1  set on any mismatch, cleared only by rst.
REQ-013 err_cnt, wr_cnt, rd_cnt  out  CNT_WIDTH each  saturating mismatch, accepted-write and accepted-read counts.
REQ-014 cov_vec  out  8  sticky hit flags, fifo_chk_cov_e bit order.

Function
REQ-015 The model SHALL hold a shadow memory of FIFO_DEPTH x DATA_WIDTH, write/read pointers wrapping at FIFO_DEPTH, and an occupancy count 0..FIFO_DEPTH.
REQ-016 Accepted write: wr_en=1 and count<FIFO_DEPTH; accepted read: rd_en=1 and count>0; both evaluated on the model count before the edge.
REQ-017 Simultaneous wr_en=rd_en=1: when count=0, write only; when count=FIFO_DEPTH, read only; otherwise both, count unchanged.
REQ-018 Combinational expectations compared every enabled edge: full=(count==FIFO_DEPTH), empty=(count==0), almostfull=(count==FIFO_DEPTH-1), almostempty=(count==1).
REQ-019 Registered expectations from edge k, compared at edge k+1: wr_ack=accepted write; overflow=wr_en and count==FIFO_DEPTH; underflow=rd_en and count==0; data_out=shadow head word, only when a read was accepted.
REQ-020 At edge k+1 the checker SHALL register mismatch bits into err_vec; err_vec holds them for exactly one cycle, then shows the next edge's result.
REQ-021 err_cnt SHALL add 1 per edge with err_vec nonzero (not per bit); all counters saturate at all-ones.
REQ-022 cov_vec bits: full, empty, almostfull, almostempty, overflow, underflow, simultaneous rd+wr accepted, pointer wrap; each set on first occurrence.
REQ-023 dut_rst_n=0 at an edge SHALL clear count, pointers and pending expectations; err_vec is forced to 0 that edge and the next.
REQ-024 With chk_en=0 the model SHALL still update, err_vec SHALL be 0 and err_cnt/err_sticky SHALL hold.

Reset
REQ-025 rst=1 SHALL asynchronously clear count, pointers, pending expectations, err_vec, err_sticky, all counters and cov_vec; shadow memory contents are don't-care.
REQ-026 Assertion of rst mid-sequence SHALL discard pending expectations; the first compare after release occurs on the second edge.

Structure
REQ-027 Package fifo_chk_pkg SHALL hold enums fifo_chk_err_e (DATA=0, WR_ACK, OVERFLOW, UNDERFLOW, FULL, EMPTY, ALMOSTFULL, ALMOSTEMPTY) and fifo_chk_cov_e, plus the bit count constants.
REQ-028 A sub-module fifo_chk_model SHALL contain shadow memory, pointers and count; the top holds comparison, counters and coverage.

Verification (DATA_WIDTH=16, FIFO_DEPTH=8)
REQ-029 Correct DUT, 8 writes 0x0001..0x0008 then 8 reads -> err_vec always 0, wr_cnt=8, rd_cnt=8, cov full/empty/almostfull/almostempty set.
REQ-030 Full FIFO, wr_en=1 with DUT overflow=1 next cycle -> no error; DUT overflow=0 -> err_vec=0x04, err_cnt=1, err_sticky=1.
REQ-031 Read of 0x0003 with DUT data_out=0x0013 -> err_vec=0x01 for exactly one cycle, err_cnt increments by 1.
REQ-032 Empty FIFO, wr_en=rd_en=1 -> model count=1, underflow expected 1, wr_ack expected 1, rd_cnt unchanged.
REQ-033 12 write/read pairs -> pointer wraps, cov wrap bit set, err_vec 0 throughout.
REQ-034 dut_rst_n=0 with count=5 -> count=0, err_vec=0 two edges; rst=1 mid-burst -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/fifo_checker_pkg.sv
// fifo_checker_pkg: shared error/coverage bit maps for the FIFO checker
package fifo_chk_pkg;
  localparam int ERR_BITS = 8;
  localparam int COV_BITS = 8;
  typedef enum logic [2:0] {
    ERR_DATA, ERR_WR_ACK, ERR_OVERFLOW, ERR_UNDERFLOW,
    ERR_FULL, ERR_EMPTY, ERR_ALMOSTFULL, ERR_ALMOSTEMPTY
  } fifo_chk_err_e;
  typedef enum logic [2:0] {
    COV_FULL, COV_EMPTY, COV_ALMOSTFULL, COV_ALMOSTEMPTY,
    COV_OVERFLOW, COV_UNDERFLOW, COV_SIMUL, COV_WRAP
  } fifo_chk_cov_e;
endpackage

// File: rtl/fifo_checker_if.sv
// fifo_checker_if: observed FIFO DUT handshake, data and status signals
interface fifo_checker_if #(parameter int DATA_WIDTH = 16);
  logic                  dut_rst_n;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  modport master (
    output dut_rst_n, wr_en, rd_en, data_in, data_out, wr_ack, overflow,
           underflow, full, empty, almostfull, almostempty
  );
  modport slave (
    input dut_rst_n, wr_en, rd_en, data_in, data_out, wr_ack, overflow,
          underflow, full, empty, almostfull, almostempty
  );
endinterface

// File: rtl/fifo_checker_model.sv
// fifo_chk_model: shadow FIFO tracking occupancy, pointers and stored words
module fifo_chk_model #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dut_rst_n_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [AW:0]           count_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  wr_acc_o,
  output logic                  rd_acc_o,
  output logic                  wrap_o
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  assign wr_acc_o = wr_en_i && (count_q != DEPTH_C);
  assign rd_acc_o = rd_en_i && (count_q != '0);
  assign wrap_o   = dut_rst_n_i && ((wr_acc_o && &wptr_q) || (rd_acc_o && &rptr_q));
  assign count_o  = count_q;
  assign head_o   = mem_q[rptr_q];
  // next pointers and occupancy; an observed DUT reset empties the model
  always_comb begin
    count_d = dut_rst_n_i ? count_q + (AW+1)'(wr_acc_o) - (AW+1)'(rd_acc_o) : '0;
    wptr_d  = dut_rst_n_i ? wptr_q + AW'(wr_acc_o) : '0;
    rptr_d  = dut_rst_n_i ? rptr_q + AW'(rd_acc_o) : '0;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end
  // shadow storage needs no reset; only occupied slots are ever read
  always_ff @(posedge clk) begin
    if (dut_rst_n_i && wr_acc_o) mem_q[wptr_q] <= data_in_i;
  end
endmodule

// File: rtl/fifo_checker.sv
// fifo_checker: compares an observed FIFO against a shadow model, with stats and coverage
module fifo_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chk_en,
  fifo_checker_if.slave        mon,
  output logic [ERR_BITS-1:0]  err_vec,
  output logic                 err_sticky,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] wr_cnt,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic [COV_BITS-1:0]  cov_vec
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] head;
  logic                  wr_acc, rd_acc, wrap;
  logic                  full_m, empty_m;
  logic [ERR_BITS-1:0]   mis, err_vec_q, err_vec_d;
  logic [COV_BITS-1:0]   hit, cov_q, cov_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                  vld_q, vld_d, exp_ack_q, exp_ack_d, exp_ov_q, exp_ov_d;
  logic                  exp_un_q, exp_un_d, exp_rd_q, exp_rd_d;
  logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
  fifo_chk_model #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_model (
    .clk         (clk),
    .rst         (rst),
    .dut_rst_n_i (mon.dut_rst_n),
    .wr_en_i     (mon.wr_en),
    .rd_en_i     (mon.rd_en),
    .data_in_i   (mon.data_in),
    .count_o     (count),
    .head_o      (head),
    .wr_acc_o    (wr_acc),
    .rd_acc_o    (rd_acc),
    .wrap_o      (wrap)
  );
  assign full_m     = count == DEPTH_C;
  assign empty_m    = count == '0;
  assign err_vec    = err_vec_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;
  assign cov_vec    = cov_q;
  // vld_q marks that the previous edge was tracked, so pending expectations and
  // status compares are trusted only from the second edge after any reset
  always_comb begin
    mis = '0;
    mis[ERR_DATA]        = exp_rd_q && (mon.data_out != exp_data_q);
    mis[ERR_WR_ACK]      = mon.wr_ack != exp_ack_q;
    mis[ERR_OVERFLOW]    = mon.overflow != exp_ov_q;
    mis[ERR_UNDERFLOW]   = mon.underflow != exp_un_q;
    mis[ERR_FULL]        = mon.full != full_m;
    mis[ERR_EMPTY]       = mon.empty != empty_m;
    mis[ERR_ALMOSTFULL]  = mon.almostfull != (count == AFULL_C);
    mis[ERR_ALMOSTEMPTY] = mon.almostempty != (count == ONE_C);
    err_vec_d = (chk_en && vld_q && mon.dut_rst_n) ? mis : '0;
    hit = '0;
    hit[COV_FULL]        = full_m;
    hit[COV_EMPTY]       = empty_m;
    hit[COV_ALMOSTFULL]  = count == AFULL_C;
    hit[COV_ALMOSTEMPTY] = count == ONE_C;
    hit[COV_OVERFLOW]    = mon.wr_en && full_m;
    hit[COV_UNDERFLOW]   = mon.rd_en && empty_m;
    hit[COV_SIMUL]       = wr_acc && rd_acc;
    hit[COV_WRAP]        = wrap;
    cov_d        = mon.dut_rst_n ? cov_q | hit : cov_q;
    err_sticky_d = err_sticky_q | (|err_vec_d);
    err_cnt_d    = (|err_vec_d && !(&err_cnt_q)) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
    wr_cnt_d     = (mon.dut_rst_n && wr_acc && !(&wr_cnt_q)) ? wr_cnt_q + CNT_WIDTH'(1) : wr_cnt_q;
    rd_cnt_d     = (mon.dut_rst_n && rd_acc && !(&rd_cnt_q)) ? rd_cnt_q + CNT_WIDTH'(1) : rd_cnt_q;
    vld_d        = mon.dut_rst_n;
    exp_ack_d    = mon.dut_rst_n && wr_acc;
    exp_ov_d     = mon.dut_rst_n && mon.wr_en && full_m;
    exp_un_d     = mon.dut_rst_n && mon.rd_en && empty_m;
    exp_rd_d     = mon.dut_rst_n && rd_acc;
    exp_data_d   = head;
  end
  // result, statistics, coverage and pending-expectation registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vec_q    <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      cov_q        <= '0;
      vld_q        <= 1'b0;
      exp_ack_q    <= 1'b0;
      exp_ov_q     <= 1'b0;
      exp_un_q     <= 1'b0;
      exp_rd_q     <= 1'b0;
      exp_data_q   <= '0;
    end else begin
      err_vec_q    <= err_vec_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      cov_q        <= cov_d;
      vld_q        <= vld_d;
      exp_ack_q    <= exp_ack_d;
      exp_ov_q     <= exp_ov_d;
      exp_un_q     <= exp_un_d;
      exp_rd_q     <= exp_rd_d;
      exp_data_q   <= exp_data_d;
    end
  end
endmodule

// File: tb/tb_fifo_checker.sv
// tb_fifo_checker: directed scenarios driving a well-behaved FIFO plus planted faults
module tb_fifo_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic        chk_en;
  logic [7:0]  err_vec, cov_vec;
  logic        err_sticky;
  logic [15:0] err_cnt, wr_cnt, rd_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];
  bit          bad_ov, bad_full, bad_empty;
  logic [15:0] data_xor;

  fifo_checker_if #(.DATA_WIDTH(16)) mon();

  fifo_checker #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .chk_en     (chk_en),
    .mon        (mon),
    .err_vec    (err_vec),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .wr_cnt     (wr_cnt),
    .rd_cnt     (rd_cnt),
    .cov_vec    (cov_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // status flags of the emulated DUT, with optional planted faults
  task automatic set_flags();
    int n;
    n = q.size();
    mon.full        = (n == 8) | bad_full;
    mon.empty       = (n == 0) ^ bad_empty;
    mon.almostfull  = n == 7;
    mon.almostempty = n == 1;
  endtask

  // one clock of the emulated DUT; returns #1 after the rising edge
  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    int   n;
    logic wa, ra;
    mon.wr_en   = w;
    mon.rd_en   = r;
    mon.data_in = d;
    @(posedge clk);
    #1;
    n  = q.size();
    wa = w && n < 8;
    ra = r && n > 0;
    if (!mon.dut_rst_n) begin
      q.delete();
      mon.wr_ack    = 1'b0;
      mon.overflow  = 1'b0;
      mon.underflow = 1'b0;
    end else begin
      mon.wr_ack    = wa;
      mon.overflow  = w && n == 8 && !bad_ov;
      mon.underflow = r && n == 0;
      if (ra) mon.data_out = q.pop_front() ^ data_xor;
      if (wa) q.push_back(d);
    end
    set_flags();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    chk_en = 1'b1;
    bad_ov = 0; bad_full = 0; bad_empty = 0; data_xor = '0;
    mon.dut_rst_n = 1'b1;
    mon.wr_en = 1'b0; mon.rd_en = 1'b0; mon.data_in = '0; mon.data_out = '0;
    mon.wr_ack = 1'b0; mon.overflow = 1'b0; mon.underflow = 1'b0;
    set_flags();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL reset_err_vec got %h exp 00", err_vec); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", err_sticky); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", wr_cnt, rd_cnt); end
    checks++; if (cov_vec !== 8'h00) begin errors++; $display("FAIL reset_cov got %h exp 00", cov_vec); end
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 16'(i));
      checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL fill_%0d err_vec got %h exp 00", i, err_vec); end
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 16'h0);
      checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL drain_%0d err_vec got %h exp 00", i, err_vec); end
    end
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL drain_last err_vec got %h exp 00", err_vec); end
    checks++; if (wr_cnt !== 16'd8 || rd_cnt !== 16'd8) begin errors++; $display("FAIL fill_cnts got %0d/%0d exp 8/8", wr_cnt, rd_cnt); end
    checks++; if (cov_vec !== 8'h8F) begin errors++; $display("FAIL fill_cov got %h exp 8f", cov_vec); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(i));
    cyc(1'b1, 1'b0, 16'h0009);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL ovf_good err_vec got %h exp 00", err_vec); end
    bad_ov = 1;
    cyc(1'b1, 1'b0, 16'h0009);
    bad_ov = 0;
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h04) begin errors++; $display("FAIL ovf_bad err_vec got %h exp 04", err_vec); end
    checks++; if (err_cnt !== 16'd1 || err_sticky !== 1'b1) begin errors++; $display("FAIL ovf_bad err_cnt/sticky got %0d/%b exp 1/1", err_cnt, err_sticky); end
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL ovf_after err_vec got %h exp 00", err_vec); end
    checks++; if (cov_vec[4] !== 1'b1) begin errors++; $display("FAIL ovf_cov got %b exp 1", cov_vec[4]); end
  endtask

  task automatic test_data();
    cyc(1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b1, 16'h0);
    data_xor = 16'h0010;
    cyc(1'b0, 1'b1, 16'h0);
    data_xor = 16'h0000;
    cyc(1'b0, 1'b1, 16'h0);
    checks++; if (err_vec !== 8'h01) begin errors++; $display("FAIL data_bad err_vec got %h exp 01", err_vec); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL data_bad err_cnt got %0d exp 2", err_cnt); end
    cyc(1'b0, 1'b1, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL data_once err_vec got %h exp 00", err_vec); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00 || err_cnt !== 16'd2) begin errors++; $display("FAIL data_drain err_vec/err_cnt got %h/%0d exp 00/2", err_vec, err_cnt); end
  endtask

  task automatic test_simul_empty();
    cyc(1'b1, 1'b1, 16'h0055);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL simul_empty err_vec got %h exp 00", err_vec); end
    checks++; if (rd_cnt !== 16'd16 || wr_cnt !== 16'd17) begin errors++; $display("FAIL simul_empty cnts got %0d/%0d exp 17/16", wr_cnt, rd_cnt); end
    checks++; if (cov_vec[5] !== 1'b1) begin errors++; $display("FAIL simul_empty cov_ufl got %b exp 1", cov_vec[5]); end
    cyc(1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL simul_read err_vec got %h exp 00", err_vec); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b0, 16'h0100);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b1, 16'h0100 + 16'(i));
      checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL wrap_%0d err_vec got %h exp 00", i, err_vec); end
    end
    cyc(1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL wrap_end err_vec got %h exp 00", err_vec); end
    checks++; if (cov_vec !== 8'hFF) begin errors++; $display("FAIL wrap_cov got %h exp ff", cov_vec); end
    checks++; if (wr_cnt !== 16'd30 || rd_cnt !== 16'd30) begin errors++; $display("FAIL wrap_cnts got %0d/%0d exp 30/30", wr_cnt, rd_cnt); end
  endtask

  task automatic test_chk_en();
    chk_en = 1'b0;
    bad_empty = 1;
    set_flags();
    cyc(1'b1, 1'b0, 16'h0200);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00 || err_cnt !== 16'd2) begin errors++; $display("FAIL chk_off err_vec/err_cnt got %h/%0d exp 00/2", err_vec, err_cnt); end
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h20 || err_cnt !== 16'd3) begin errors++; $display("FAIL chk_on err_vec/err_cnt got %h/%0d exp 20/3", err_vec, err_cnt); end
    bad_empty = 0;
    set_flags();
    cyc(1'b0, 1'b1, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL chk_track err_vec got %h exp 00", err_vec); end
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL chk_read err_vec got %h exp 00", err_vec); end
  endtask

  task automatic test_dut_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0300 + 16'(i));
    bad_full = 1;
    set_flags();
    mon.dut_rst_n = 1'b0;
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL dutrst_edge0 err_vec got %h exp 00", err_vec); end
    mon.dut_rst_n = 1'b1;
    set_flags();
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL dutrst_edge1 err_vec got %h exp 00", err_vec); end
    bad_full = 0;
    set_flags();
    cyc(1'b1, 1'b0, 16'h0310);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL dutrst_count0 err_vec got %h exp 00", err_vec); end
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL dutrst_count1 err_vec got %h exp 00", err_vec); end
    cyc(1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL dutrst_read err_vec got %h exp 00", err_vec); end
  endtask

  task automatic test_async_rst();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0400 + 16'(i));
    #2;
    rst = 1'b1;
    #1;
    checks++; if (err_vec !== 8'h00 || err_sticky !== 1'b0 || err_cnt !== 16'd0) begin errors++; $display("FAIL arst_err got %h/%b/%0d exp 00/0/0", err_vec, err_sticky, err_cnt); end
    checks++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || cov_vec !== 8'h00) begin errors++; $display("FAIL arst_stats got %0d/%0d/%h exp 0/0/00", wr_cnt, rd_cnt, cov_vec); end
    q.delete();
    mon.wr_en = 1'b0; mon.rd_en = 1'b0;
    mon.wr_ack = 1'b0; mon.overflow = 1'b0; mon.underflow = 1'b0;
    set_flags();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad_full = 1;
    set_flags();
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL arst_first err_vec got %h exp 00", err_vec); end
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h10 || err_cnt !== 16'd1) begin errors++; $display("FAIL arst_second err_vec/err_cnt got %h/%0d exp 10/1", err_vec, err_cnt); end
    bad_full = 0;
    set_flags();
    cyc(1'b0, 1'b0, 16'h0);
    checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL arst_clean err_vec got %h exp 00", err_vec); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_data();
    test_simul_empty();
    test_wrap();
    test_chk_en();
    test_dut_reset();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
